// File: rtl/regfile_arbiter_pkg.sv
// Shared definitions for the register-file arbiter.
// Default widths and FSM state encodings.
package regfile_arbiter_pkg;

  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// Two-input round-robin picker.
// On contention the side that did not win last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_winner,
  output logic [1:0] win
);

  // one-hot winner; bit 0 = A, bit 1 = B
  always_comb begin
    win = req;
    if (req == 2'b11) begin
      win = last_winner ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates two requesters onto a shared register file.
// IDLE -> ACCESS -> DONE, all state on the falling clock edge.
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int   ADDR_W     = ADDR_W_DEF,
  parameter int   DATA_W     = DATA_W_DEF,
  parameter logic FIRST_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_dsel,
  output logic [ADDR_W-1:0] rf_msel,
  output logic [DATA_W-1:0] rf_din,
  input  logic [DATA_W-1:0] rf_q
);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        win;
  logic              last_winner;
  logic              op_side;
  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic              start;

  assign start = (state == ST_IDLE) && (a_req || b_req);

  rr_arb2 u_arb (
    .req         ({b_req, a_req}),
    .last_winner (last_winner),
    .win         (win)
  );

  // state register, falling edge to match the register file
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state: one state per clock period
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (a_req || b_req) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // latch the winner's op; frozen until the next grant
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      last_winner <= ~FIRST_PRIO;
      op_side     <= 1'b0;
      op_we       <= 1'b0;
      op_addr     <= '0;
      op_wdata    <= '0;
    end else if (start) begin
      last_winner <= win[1];
      op_side     <= win[1];
      op_we       <= win[1] ? b_we    : a_we;
      op_addr     <= win[1] ? b_addr  : a_addr;
      op_wdata    <= win[1] ? b_wdata : a_wdata;
    end
  end

  // capture the file's read data on the edge ending ACCESS
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (state == ST_ACCESS && !op_we) begin
      if (op_side) begin
        b_rdata <= rf_q;
      end else begin
        a_rdata <= rf_q;
      end
    end
  end

  // outputs decoded from state so clr drops them at once
  always_comb begin
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    a_done   = 1'b0;
    b_done   = 1'b0;
    rf_write = 1'b0;
    rf_dsel  = op_addr;
    rf_msel  = op_addr;
    rf_din   = op_wdata;
    unique case (state)
      ST_ACCESS: begin
        a_gnt    = !op_side;
        b_gnt    = op_side;
        rf_write = op_we;
      end
      ST_DONE: begin
        a_gnt  = !op_side;
        b_gnt  = op_side;
        a_done = !op_side;
        b_done = op_side;
      end
      default: ;
    endcase
  end

endmodule
